// File: rtl/dec5_32_reg.sv
// dec5_32_reg: registered 5-to-32 enabled one-hot decoder.
// The decode is built as a tree of enabled 1:2 decoders (1:2 -> 2:4 -> 3:8
// -> 4:16, then a top 1:2 split into two 4:16 halves) followed by a 32-bit
// output register with asynchronous active-low reset.
// Optional macro DEC_GATE_DELAY_EN: when defined, every NOT/AND gate in the
// tree carries the standard gate delay GATE_DELAY (normally supplied by
// delays.sv ahead of this file; defaults to 1 time unit if absent).
// When undefined, all gates are zero-delay.

`ifdef DEC_GATE_DELAY_EN
`ifndef GATE_DELAY
`define GATE_DELAY 1
`endif
`endif

// Leaf: enabled 1:2 decoder built from gates.
module decoder1_2 (
    input  logic       en,
    input  logic       sel,
    output logic [1:0] out
);
    logic sel_b;

`ifdef DEC_GATE_DELAY_EN
    not #(`GATE_DELAY) g_inv (sel_b, sel);
    and #(`GATE_DELAY) g_hi  (out[1], en, sel);
    and #(`GATE_DELAY) g_lo  (out[0], en, sel_b);
`else
    not g_inv (sel_b, sel);
    and g_hi  (out[1], en, sel);
    and g_lo  (out[0], en, sel_b);
`endif
endmodule

// Enabled 2:4 decoder: sel[1] picks which 1:2 leaf is enabled.
module decoder2_4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] out
);
    logic [1:0] half_en;

    decoder1_2 u_split (.en(en),         .sel(sel[1]), .out(half_en));
    decoder1_2 u_hi    (.en(half_en[1]), .sel(sel[0]), .out(out[3:2]));
    decoder1_2 u_lo    (.en(half_en[0]), .sel(sel[0]), .out(out[1:0]));
endmodule

// Enabled 3:8 decoder: sel[2] picks which 2:4 half is enabled.
module decoder3_8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] out
);
    logic [1:0] half_en;

    decoder1_2 u_split (.en(en),         .sel(sel[2]),   .out(half_en));
    decoder2_4 u_hi    (.en(half_en[1]), .sel(sel[1:0]), .out(out[7:4]));
    decoder2_4 u_lo    (.en(half_en[0]), .sel(sel[1:0]), .out(out[3:0]));
endmodule

// Enabled 4:16 decoder: sel[3] picks which 3:8 half is enabled.
module decoder4_16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] out
);
    logic [1:0] half_en;

    decoder1_2 u_split (.en(en),         .sel(sel[3]),   .out(half_en));
    decoder3_8 u_hi    (.en(half_en[1]), .sel(sel[2:0]), .out(out[15:8]));
    decoder3_8 u_lo    (.en(half_en[0]), .sel(sel[2:0]), .out(out[7:0]));
endmodule

// Top: sel[4] chooses the upper or lower 4:16 half, result is registered.
module dec5_32_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [4:0]  sel,
    output logic [31:0] out
);
    logic [1:0]  half_en;
    logic [31:0] dec;

    decoder1_2  u_split (.en(en),         .sel(sel[4]),   .out(half_en));
    decoder4_16 u_hi    (.en(half_en[1]), .sel(sel[3:0]), .out(dec[31:16]));
    decoder4_16 u_lo    (.en(half_en[0]), .sel(sel[3:0]), .out(dec[15:0]));

    // Capture the settled decode each edge; reset clears it immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= 32'h0;
        end else begin
            out <= dec;
        end
    end
endmodule

// File: tb/tb_dec5_32_reg.sv
// Bench for dec5_32_reg plus standalone decoder1_2 / decoder4_16.
// Expected values come from a plain arithmetic model: en ? 1 << sel : 0,
// delayed by one clock for the registered top.
module tb_dec5_32_reg;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] out;

    logic        en12;
    logic        sel12;
    logic [1:0]  out12;
    logic        en16;
    logic [3:0]  sel16;
    logic [15:0] out16;

    int checks = 0;
    int errors = 0;

    dec5_32_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .sel     (sel),
        .out     (out)
    );

    decoder1_2 u_d12 (.en(en12), .sel(sel12), .out(out12));
    decoder4_16 u_d16 (.en(en16), .sel(sel16), .out(out16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_dec(input logic e, input int s);
        logic [31:0] one;
        one = 32'd1;
        return e ? (one << s) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge capture them, sample 1 unit later.
    task automatic cycle(input logic e, input logic [4:0] s);
        en  = e;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        logic        re;
        logic [4:0]  rs;

        reset_n = 1'b0;
        en      = 1'b1;
        sel     = 5'd7;
        en12 = 1'b0; sel12 = 1'b0; en16 = 1'b0; sel16 = 4'd0;
        #2;
        chk("reset_initial", out, 32'h0);

        // Clock running with reset low: edges must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", out, 32'h0);
        end

        // Release: first edge with reset_n high captures en=1, sel=7.
        reset_n = 1'b1;
        cycle(1'b1, 5'd7);
        chk("reset_release", out, 32'h0000_0080);

        // Asynchronous clear mid-cycle, no edge needed.
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_async", out, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_async_hold", out, 32'h0);
        reset_n = 1'b1;

        // Exhaustive {en,sel} sweep.
        for (int i = 0; i < 64; i++) begin
            cycle(i[5], i[4:0]);
            chk($sformatf("sweep_%0d", i), out, ref_dec(i[5], i[4:0]));
        end

        cycle(1'b1, 5'd0);
        chk("sel0", out, 32'h0000_0001);
        cycle(1'b1, 5'd31);
        chk("sel31", out, 32'h8000_0000);

        // Half boundary across the top split.
        cycle(1'b1, 5'd15);
        chk("half_15", out, 32'h0000_8000);
        cycle(1'b1, 5'd16);
        chk("half_16", out, 32'h0001_0000);

        // Latency: bit 3 for exactly one cycle, stable between edges.
        cycle(1'b1, 5'd3);
        chk("lat_3", out, 32'h0000_0008);
        sel = 5'd9;
        #3;
        chk("lat_3_stable", out, 32'h0000_0008);
        @(posedge clk);
        #1;
        chk("lat_9", out, 32'h0000_0200);

        // Enable toggle.
        cycle(1'b1, 5'd20);
        chk("tog_1", out, 32'h0010_0000);
        cycle(1'b0, 5'd20);
        chk("tog_0", out, 32'h0);
        cycle(1'b1, 5'd20);
        chk("tog_1b", out, 32'h0010_0000);

        // Random stimulus against the model, including the one-hot invariant.
        for (int i = 0; i < 200; i++) begin
            re = 1'($urandom_range(0, 1));
            rs = 5'($urandom_range(0, 31));
            exp_v = ref_dec(re, rs);
            cycle(re, rs);
            chk("rand", out, exp_v);
            chk("rand_popcount", 32'($countones(out)), 32'(re));
        end

        // Standalone decoder1_2.
        for (int i = 0; i < 4; i++) begin
            en12  = i[1];
            sel12 = i[0];
            #1;
            chk($sformatf("d12_%0d", i), {30'd0, out12}, ref_dec(i[1], i[0]));
        end

        // Standalone decoder4_16.
        for (int i = 0; i < 32; i++) begin
            en16  = i[4];
            sel16 = i[3:0];
            #1;
            chk($sformatf("d16_%0d", i), {16'd0, out16}, ref_dec(i[4], i[3:0]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
